// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared sequencer state enum, PC increment and jump-target field widths
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2,
    HALT    = 2'd3
  } seq_state_t;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          JUMP_INDEX_W = 26;
  localparam int          JUMP_SEG_W   = 4;

  // J-type target: segment of the delay-slot PC, index field, word offset
  function automatic logic [31:0] jump_target(input logic [31:0]             pc_plus4,
                                              input logic [JUMP_INDEX_W-1:0] index);
    return {pc_plus4[31:32-JUMP_SEG_W], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - holds one redirect that arrived while the fetch PC was frozen
module pc_redirect_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_target,
  input  logic        clear,
  output logic        pending_valid,
  output logic [31:0] pending_target
);

  // A later redirect simply overwrites an earlier one: the last one wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_valid  <= 1'b0;
      pending_target <= 32'h0;
    end else if (load) begin
      pending_valid  <= 1'b1;
      pending_target <= load_target;
    end else if (clear) begin
      pending_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch PC sequencer with stall buffering and misalign halt; INSTR_COUNT_EN adds a fetch counter
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic                    branch_taken_i,
  input  logic [31:0]             branch_target_i,
  input  logic                    jump_i,
  input  logic [JUMP_INDEX_W-1:0] jump_index_i,
  output logic [31:0]             pc_o,
  output logic [31:0]             pc_plus4_o,
  output logic                    fetch_valid_o,
  output logic                    halt_o,
  output logic [31:0]             instr_count_o
);

  seq_state_t  state, state_next;
  logic [31:0] pc_q, pc_next;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        apply;
  logic [31:0] apply_target;
  logic        buf_load, buf_clear;
  logic        pending_valid;
  logic [31:0] pending_target;

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + PC_INC;
  assign redir_valid   = jump_i | branch_taken_i;
  assign redir_target  = jump_i ? jump_target(pc_plus4_o, jump_index_i) : branch_target_i;
  assign fetch_valid_o = (state == RUN) && !stall_i;
  assign halt_o        = (state == HALT);

  pc_redirect_buffer u_redirect_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (buf_load),
    .load_target    (redir_target),
    .clear          (buf_clear),
    .pending_valid  (pending_valid),
    .pending_target (pending_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    apply        = 1'b0;
    apply_target = redir_target;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (stall_i) begin
          state_next = STALLED;
          buf_load   = redir_valid;
        end else if (redir_valid) begin
          apply = 1'b1;
        end else begin
          pc_next = pc_plus4_o;
        end
      end
      STALLED: begin
        if (stall_i) begin
          buf_load = redir_valid;
        end else begin
          // A fresh redirect on the release cycle is newer than the buffered one
          state_next = RUN;
          buf_clear  = 1'b1;
          if (redir_valid) begin
            apply = 1'b1;
          end else if (pending_valid) begin
            apply        = 1'b1;
            apply_target = pending_target;
          end
        end
      end
      default: state_next = HALT;
    endcase
    if (apply) begin
      if ((apply_target[1:0] != 2'b00) && HALT_ON_MISALIGN) begin
        state_next = HALT;
        pc_next    = pc_q;
      end else begin
        pc_next = {apply_target[31:2], 2'b00};
      end
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= 32'h0;
    end else if (fetch_valid_o) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign instr_count_o = instr_count_q;
`else
  assign instr_count_o = 32'h0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 32-bit MIPS single-cycle core. It owns the architectural PC and produces PC+4, which feeds the branch-target adder. It consumes the resolved branch target and the jump target from decode and selects the next PC. It also handles stalls, buffers any redirect that arrives during a stall, and halts on a misaligned target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- HALT_ON_MISALIGN, 1, 1: a misaligned redirect enters HALT; 0: the target is forced aligned (bits [1:0] cleared) and execution continues.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- stall_i  in  1  freeze the PC this cycle.
- branch_taken_i  in  1  branch resolved taken this cycle.
- branch_target_i  in  32  branch target from the branch adder.
- jump_i  in  1  J/JAL this cycle.
- jump_index_i  in  26  instruction index field.
- pc_o  out  32  current fetch PC.
- pc_plus4_o  out  32  pc_o + 4, combinational, modulo 2^32.
- fetch_valid_o  out  1  pc_o is a valid fetch this cycle.
- halt_o  out  1  sequencer halted.
- instr_count_o  out  32  fetched-instruction count (see Configuration).

## Operation
- States: BOOT, RUN, STALLED, HALT.
- Reset values: state=BOOT, pc_o=RESET_PC, fetch_valid_o=0, halt_o=0, pending_valid=0, instr_count_o=0.
- BOOT: always moves to RUN after one edge. No fetch is issued in BOOT.
- Jump target = {pc_plus4_o[31:28], jump_index_i, 2'b00}.
- Redirect priority: jump_i over branch_taken_i. The redirect target is the jump target if jump_i=1, else branch_target_i if branch_taken_i=1, else none.
- RUN with stall_i=0:
  - No redirect: pc <= pc+4.
  - Redirect: pc <= target.
- RUN with stall_i=1: pc holds and the state moves to STALLED. Any redirect presented in the same cycle is latched into pending_target with pending_valid set.
- STALLED, fetch_valid_o=0:
  - A new redirect overwrites pending_target. The last one wins.
  - When stall_i drops, the state returns to RUN. If pending_valid=1, pc <= pending_target, else pc holds. pending_valid clears in both cases.
  - Redirect inputs on the release cycle take priority over the pending target.
- Misaligned target (target[1:0]≠0):
  - HALT_ON_MISALIGN=1: pc does not change and the state moves to HALT.
  - HALT_ON_MISALIGN=0: pc loads {target[31:2],2'b00}.
- HALT: absorbing. halt_o=1 and fetch_valid_o=0 until rst_n asserts.
- Wrap-around: pc 32'hFFFF_FFFC with +4 gives 32'h0000_0000. No flag is raised.
- Reset mid-stall or mid-HALT: all state returns to reset values immediately and asynchronously.

## Timing
- fetch_valid_o = (state==RUN) && !stall_i.
- A redirect is sampled at edge N; pc_o shows the target after edge N. There are no bubbles.
- Recovery from a stall takes one edge after stall_i falls; pc_o shows the pending target after that edge.
- Misalignment detected at edge N: halt_o=1 after edge N.
- pc_plus4_o is purely combinational from pc_o, with no added latency.
- Deassertion of rst_n is synchronised externally. The first valid fetch occurs in the second cycle after release.

## Configuration
- INSTR_COUNT_EN defined: a 32-bit counter increments on every cycle where fetch_valid_o=1. It wraps at 2^32 and clears on reset. The counter drives instr_count_o.
- INSTR_COUNT_EN undefined: no counter is built and instr_count_o is tied to 32'h0.

## Structure
- Shared package mips_pkg holds:
  - the state enum (BOOT, RUN, STALLED, HALT),
  - the PC_INC=4 constant,
  - the jump-target width constants (26-bit index, 4-bit segment).
- One sub-module, pc_redirect_buffer, is natural: it holds the pending_valid/pending_target register with its overwrite and clear rules.
- The adder, next-PC mux and state machine stay in pc_sequencer.

## Test plan
- Reset with RESET_PC=32'h0040_0000, release, 4 cycles with no stall -> pc_o sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; fetch_valid_o low only in the BOOT cycle.
- At pc=0x00400010, branch_taken_i=1, branch_target_i=0x00400100 -> pc_o=0x00400100 after the edge. Repeat with jump_i=1 as well and jump_index_i=0x0000040 -> jump wins, pc_o=0x00000100.
- stall_i=1 for 3 cycles; branch to 0x500 in cycle 1, then branch to 0x600 in cycle 2 -> pc_o held, fetch_valid_o=0 throughout; after release pc_o=0x600.
- branch_target_i=0x00400102 with HALT_ON_MISALIGN=1 -> halt_o=1 next cycle, pc_o unchanged, fetch_valid_o=0. With HALT_ON_MISALIGN=0 -> pc_o=0x00400100.
- pc=0xFFFFFFFC with no redirect -> pc_o=0x00000000. Assert rst_n=0 mid-stall -> pc_o=RESET_PC and state BOOT immediately.
- INSTR_COUNT_EN defined: 10 valid fetches plus 3 stalled cycles -> instr_count_o=10. Undefined -> instr_count_o stays 0.
